// File: rtl/oled_pkg.sv
// Shared constants and types for the SSD1331 power sequencers.
package oled_pkg;

  localparam int unsigned VCC_OFF_WAIT_US = 400_000;
  localparam int unsigned SPI_TIMEOUT_US  = 1_000;
  localparam int unsigned DEBUG_WAIT_US   = 10;
  localparam int          CLOCK_COUNT_W   = 32;

  localparam logic [7:0] OLED_CMD_DISPLAY_OFF = 8'hAE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_OFF,
    S_WAIT_SPI,
    S_DISABLE_VCC,
    S_WAIT_DISCHARGE,
    S_DONE
  } off_state_e;

endpackage

// File: rtl/oled_power_off_if.sv
// Command-byte handshake between a sequencer and the SPI byte master.
interface oled_power_off_if;

  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       spi_done;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  spi_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output spi_done
  );

endinterface

// File: rtl/oled_power_off_timer.sv
// Microsecond one-shot: update_match loads a duration in us, done pulses
// once when it has elapsed.
module timer_microseconds #(
  parameter int unsigned CLOCK_FREQUENCY_HZ = 200_000_000,
  parameter int          CLOCK_COUNT_W      = 32
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     update_match,
  input  logic [CLOCK_COUNT_W-1:0] match,
  output logic                     done
);

  localparam int unsigned CYC_PER_US = CLOCK_FREQUENCY_HZ / 1_000_000;
  localparam int PRE_W = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_US - 1);

  logic [PRE_W-1:0]         pre_cnt;
  logic [CLOCK_COUNT_W-1:0] us_cnt;
  logic [CLOCK_COUNT_W-1:0] target;
  logic                     running;
  logic                     tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
      target  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (update_match) begin
        target  <= match;
        us_cnt  <= '0;
        pre_cnt <= '0;
        running <= (match != '0);
      end else if (running) begin
        if (tick) begin
          pre_cnt <= '0;
          us_cnt  <= us_cnt + 1'b1;
          if (us_cnt + 1'b1 == target) begin
            done    <= 1'b1;
            running <= 1'b0;
          end
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/oled_power_off.sv
// SSD1331 power-down: Display-Off over SPI, drop VCC, wait for
// discharge, then drop PMOD power and reset.
module oled_power_off
  import oled_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY_HZ = 200_000_000,
  parameter bit          DEBUG              = 1'b0
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              dc_c,
  output logic              res,
  output logic              vss_en,
  output logic              pmod_en,
  oled_power_off_if.master  spi
);

  localparam logic [CLOCK_COUNT_W-1:0] SPI_WAIT_US =
    CLOCK_COUNT_W'(DEBUG ? DEBUG_WAIT_US : SPI_TIMEOUT_US);
  localparam logic [CLOCK_COUNT_W-1:0] VCC_WAIT_US =
    CLOCK_COUNT_W'(DEBUG ? DEBUG_WAIT_US : VCC_OFF_WAIT_US);

  off_state_e               state;
  logic                     start_r;
  logic                     start_edge;
  logic                     spi_exit;
  logic                     tmr_load;
  logic                     tmr_done;
  logic [CLOCK_COUNT_W-1:0] tmr_match;

  assign start_edge = start && !start_r;

  // The discharge wait starts on the same edge that drops VCC.
  assign spi_exit =
    ((state == S_WAIT_SPI) && (spi.spi_done || tmr_done)) ||
    ((state == S_SEND_OFF) && tmr_done);

  assign tmr_load  = ((state == S_IDLE) && start_edge) || spi_exit;
  assign tmr_match = (state == S_IDLE) ? SPI_WAIT_US : VCC_WAIT_US;

  timer_microseconds #(
    .CLOCK_FREQUENCY_HZ (CLOCK_FREQUENCY_HZ),
    .CLOCK_COUNT_W      (CLOCK_COUNT_W)
  ) u_timer (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .update_match (tmr_load),
    .match        (tmr_match),
    .done         (tmr_done)
  );

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      start_r       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      dc_c          <= 1'b0;
      res           <= 1'b1;
      vss_en        <= 1'b1;
      pmod_en       <= 1'b1;
      spi.cmd_valid <= 1'b0;
      spi.cmd_data  <= 8'h00;
    end else begin
      start_r <= start;
      done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start_edge) begin
            busy          <= 1'b1;
            error         <= 1'b0;
            dc_c          <= 1'b0;
            spi.cmd_valid <= 1'b1;
            spi.cmd_data  <= OLED_CMD_DISPLAY_OFF;
            state         <= S_SEND_OFF;
          end
        end
        S_SEND_OFF: begin
          if (tmr_done) begin
            spi.cmd_valid <= 1'b0;
            error         <= 1'b1;
            vss_en        <= 1'b0;
            state         <= S_DISABLE_VCC;
          end else if (spi.cmd_ready) begin
            spi.cmd_valid <= 1'b0;
            state         <= S_WAIT_SPI;
          end
        end
        S_WAIT_SPI: begin
          if (spi.spi_done) begin
            vss_en <= 1'b0;
            state  <= S_DISABLE_VCC;
          end else if (tmr_done) begin
            error  <= 1'b1;
            vss_en <= 1'b0;
            state  <= S_DISABLE_VCC;
          end
        end
        S_DISABLE_VCC: begin
          state <= S_WAIT_DISCHARGE;
        end
        S_WAIT_DISCHARGE: begin
          if (tmr_done) begin
            pmod_en <= 1'b0;
            res     <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_power_off.sv
// Randomized bench for oled_power_off (DEBUG waits, 100 MHz).
module tb_oled_power_off;
  import oled_pkg::*;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, dc_c, res, vss_en, pmod_en;

  oled_power_off_if spi ();

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // 10 us at 100 MHz
  localparam int WAIT_CYC = 1000;
  localparam int RST_OUTS = 7;

  always #5 sclk = ~sclk;

  oled_power_off #(
    .CLOCK_FREQUENCY_HZ (100_000_000),
    .DEBUG              (1'b1)
  ) dut (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .dc_c    (dc_c),
    .res     (res),
    .vss_en  (vss_en),
    .pmod_en (pmod_en),
    .spi     (spi.master)
  );

  int hs_n = 0, hs_c = -1;
  int v_rise = -1, v_fall = -1, bad_n = 0;
  int vss_fall = -1, vss_hi = 0, pmod_fall = -1, res_fall = -1;
  int done_n = 0, done_c = -1, busy_fall = -1, busy_fall_n = 0;
  logic pv = 1'b0, pvss = 1'b1, ppmod = 1'b1, pres = 1'b1, pbusy = 1'b0;

  always @(posedge sclk) begin
    cyc = cyc + 1;
    if (spi.cmd_valid && spi.cmd_ready) begin
      hs_n++;
      hs_c = cyc;
    end
  end

  always @(negedge sclk) begin
    if (spi.cmd_valid && !pv) v_rise = cyc;
    if (!spi.cmd_valid && pv) v_fall = cyc;
    if (spi.cmd_valid && spi.cmd_data != OLED_CMD_DISPLAY_OFF) bad_n++;
    if (!vss_en && pvss) vss_fall = cyc;
    if (vss_en) vss_hi++;
    if (!pmod_en && ppmod) pmod_fall = cyc;
    if (!res && pres) res_fall = cyc;
    if (done) begin
      done_n++;
      done_c = cyc;
    end
    if (!busy && pbusy) begin
      busy_fall = cyc;
      busy_fall_n++;
    end
    pv    = spi.cmd_valid;
    pvss  = vss_en;
    ppmod = pmod_en;
    pres  = res;
    pbusy = busy;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  function automatic int outs();
    return int'({busy, done, error, spi.cmd_valid, spi.cmd_data,
                 dc_c, res, vss_en, pmod_en});
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    start         = 1'b0;
    spi.cmd_ready = 1'b0;
    spi.spi_done  = 1'b0;
    step(2);
    chk("rst_outs", outs(), RST_OUTS);
    rst_n = 1'b1;
    step(1);
  endtask

  // mode 0: normal spi_done, 1: never, 2: same cycle as timeout,
  // 3: one cycle after timeout
  task automatic do_run(input int mode, input bit extra, input bit fresh);
    int c0, rd, h, tt, s, hold, k, vexp, perr;
    int hs0, done0, bad0, vhi0, bf0, dly;
    c0   = cyc;
    rd   = $urandom_range(2, 60);
    h    = c0 + 2 + rd;
    tt   = c0 + 2 + WAIT_CYC;
    case (mode)
      0:       s = h + $urandom_range(1, 40);
      1:       s = -1;
      2:       s = tt;
      default: s = tt + 1;
    endcase
    perr  = (s < 0 || s > tt) ? 1 : 0;
    vexp  = perr ? tt : s;
    hold  = $urandom_range(6, 2500);
    hs0   = hs_n;
    done0 = done_n;
    bad0  = bad_n;
    vhi0  = vss_hi;
    bf0   = busy_fall_n;
    spi.cmd_ready = 1'b0;
    spi.spi_done  = 1'b0;
    start = 1'b1;
    k = 0;
    while (!(done_n > done0 && cyc > done_c + 2) && k < 4000) begin
      step(1);
      k++;
      start = (extra && k == 3) ? 1'b0 : (k < hold);
      if (cyc + 1 == h) spi.cmd_ready = 1'b1;
      else if (cyc + 1 > h) spi.cmd_ready = 1'($urandom_range(0, 1));
      else spi.cmd_ready = 1'b0;
      spi.spi_done = (cyc + 1 == s) || (cyc + 1 == c0 + 2);
    end
    start         = 1'b0;
    spi.cmd_ready = 1'b0;
    spi.spi_done  = 1'b0;
    step(2);
    chk("valid_rise", v_rise, c0 + 1);
    chk("hs_count", hs_n - hs0, 1);
    chk("hs_cyc", hs_c, h);
    chk("valid_fall", v_fall, h);
    chk("data_ae", bad_n - bad0, 0);
    chk("error", int'(error), perr);
    chk("done_count", done_n - done0, 1);
    dly = done_c - vexp;
    chk("vss_to_done", int'(dly >= WAIT_CYC && dly <= WAIT_CYC + 2), 1);
    chk("busy_fall", busy_fall, done_c + 1);
    chk("busy_cont", busy_fall_n - bf0, 1);
    if (fresh) begin
      chk("vss_fall", vss_fall, vexp);
      dly = pmod_fall - vss_fall;
      chk("pmod_dly", int'(dly >= WAIT_CYC - 1 && dly <= WAIT_CYC + 1), 1);
      chk("res_fall", res_fall, pmod_fall);
      chk("done_cyc", done_c, pmod_fall + 1);
    end else begin
      chk("vss_stay_low", vss_hi - vhi0, 0);
      chk("pmod_stay_low", int'(pmod_en), 0);
    end
  endtask

  task automatic mid_reset();
    int k, d0;
    do_reset();
    start = 1'b1;
    step(1);
    start = 1'b0;
    k = 0;
    while (!spi.cmd_valid && k < 10) begin
      step(1);
      k++;
    end
    chk("mid_valid", int'(spi.cmd_valid), 1);
    spi.cmd_ready = 1'b1;
    step(1);
    spi.cmd_ready = 1'b0;
    step(5);
    spi.spi_done = 1'b1;
    step(1);
    spi.spi_done = 1'b0;
    step(300);
    chk("mid_vss_low", int'(vss_en), 0);
    d0    = done_n;
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_outs", outs(), RST_OUTS);
    rst_n = 1'b1;
    step(1200);
    chk("mid_no_done", done_n - d0, 0);
    chk("mid_outs_hold", outs(), RST_OUTS);
  endtask

  initial begin
    spi.cmd_ready = 1'b0;
    spi.spi_done  = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_run(i % 4, 1'($urandom_range(0, 1)), 1'b1);
      do_reset();
    end
    do_run(1, 1'b0, 1'b1);
    do_run(0, 1'b1, 1'b0);
    do_run(2, 1'b0, 1'b0);
    mid_reset();
    do_run(0, 1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
